// File: rtl/nolinear_ctrl_if.sv
// Request/status and datapath control-word bundle for nolinear_ctrl.
// master = requester/observer side, slave = controller side.
interface nolinear_ctrl_if;
    logic       start;
    logic [1:0] op_mode;
    logic       flush;
    logic       busy;
    logic       in_ack;
    logic       done;
    logic [1:0] mode;
    logic       valid;
    logic [2:0] s_in;
    logic       s_mux;
    logic [2:0] s_mult;
    logic       s_add;
    logic       en_add;
    logic       en_mult;

    modport master (
        output start, op_mode, flush,
        input  busy, in_ack, done, mode, valid, s_in, s_mux, s_mult, s_add, en_add, en_mult
    );

    modport slave (
        input  start, op_mode, flush,
        output busy, in_ack, done, mode, valid, s_in, s_mux, s_mult, s_add, en_add, en_mult
    );
endinterface

// File: rtl/nolinear_ctrl.sv
// Pass sequencer for a pipelined nonlinear datapath (softmax/gelu/silu/root), fully registered outputs.
// Optional NOLINEAR_CTRL_PERF_EN adds saturating op_cnt/drop_cnt performance counters.
module nolinear_ctrl #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    nolinear_ctrl_if.slave     io_bus
`ifdef NOLINEAR_CTRL_PERF_EN
    ,
    output logic [15:0]        o_op_cnt,
    output logic [15:0]        o_drop_cnt
`endif
);

    typedef enum logic [2:0] {StIdle, StPass1, StPass2, StDone, StFlush} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_mode, w_mode_nxt;

    logic       r_busy, r_in_ack, r_done, r_p, r_en_add, r_en_mult;
    logic [2:0] r_sel;

    logic       w_pass, w_p, w_two, w_busy_nxt, w_ack_nxt, w_done_nxt;
    logic       w_en_add_nxt, w_en_mult_nxt;
    logic [2:0] w_sel_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        case (r_state)
            StIdle: begin
                if (io_bus.start && !io_bus.flush) begin
                    w_state_nxt = StPass1;
                    w_mode_nxt  = io_bus.op_mode;
                end
            end
            StPass1: begin
                if (io_bus.flush) begin
                    w_state_nxt = StFlush;
                end else if (r_cnt == LastCnt) begin
                    w_state_nxt = (r_mode[1] == r_mode[0]) ? StPass2 : StDone;
                end
            end
            StPass2: begin
                if (io_bus.flush) begin
                    w_state_nxt = StFlush;
                end else if (r_cnt == LastCnt) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = io_bus.flush ? StFlush : StIdle;
            StFlush: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        // Counter clears on every state entry and only advances within a pass.
        if ((w_state_nxt == r_state) && ((r_state == StPass1) || (r_state == StPass2))) begin
            w_cnt_nxt = r_cnt + CntOne;
        end else begin
            w_cnt_nxt = '0;
        end
    end

    // Outputs decoded from the next state so the registered word lines up with the state.
    always_comb begin
        w_pass        = (w_state_nxt == StPass1) || (w_state_nxt == StPass2);
        w_p           = (w_state_nxt == StPass2);
        w_two         = (w_mode_nxt[1] == w_mode_nxt[0]);
        w_busy_nxt    = (w_state_nxt != StIdle);
        w_ack_nxt     = (w_state_nxt == StPass1) && (r_state == StIdle);
        w_done_nxt    = (w_state_nxt == StDone);
        w_sel_nxt     = w_pass ? {w_p, w_mode_nxt} : 3'b000;
        w_en_add_nxt  = w_pass && !w_p && w_two;
        w_en_mult_nxt = w_pass && (w_p || w_two);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_mode    <= 2'b00;
            r_busy    <= 1'b0;
            r_in_ack  <= 1'b0;
            r_done    <= 1'b0;
            r_sel     <= 3'b000;
            r_p       <= 1'b0;
            r_en_add  <= 1'b0;
            r_en_mult <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mode    <= w_mode_nxt;
            r_busy    <= w_busy_nxt;
            r_in_ack  <= w_ack_nxt;
            r_done    <= w_done_nxt;
            r_sel     <= w_sel_nxt;
            r_p       <= w_p;
            r_en_add  <= w_en_add_nxt;
            r_en_mult <= w_en_mult_nxt;
        end
    end

    assign io_bus.busy    = r_busy;
    assign io_bus.in_ack  = r_in_ack;
    assign io_bus.done    = r_done;
    assign io_bus.mode    = r_mode;
    assign io_bus.valid   = r_p;
    assign io_bus.s_in    = r_sel;
    assign io_bus.s_mult  = r_sel;
    assign io_bus.s_mux   = r_p;
    assign io_bus.s_add   = r_p;
    assign io_bus.en_add  = r_en_add;
    assign io_bus.en_mult = r_en_mult;

`ifdef NOLINEAR_CTRL_PERF_EN
    logic [15:0] r_op_cnt, r_drop_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_cnt   <= 16'h0000;
            r_drop_cnt <= 16'h0000;
        end else begin
            if ((r_state == StDone) && (r_op_cnt != 16'hFFFF)) begin
                r_op_cnt <= r_op_cnt + 16'd1;
            end
            if ((r_state != StIdle) && io_bus.start && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_op_cnt   = r_op_cnt;
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_nolinear_ctrl.sv
// Self-checking bench for nolinear_ctrl: elapsed-time reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_nolinear_ctrl;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;

    nolinear_ctrl_if bus ();
`ifdef NOLINEAR_CTRL_PERF_EN
    logic [15:0] op_cnt, drop_cnt;
`endif

    nolinear_ctrl #(.LATENCY(L), .CNT_W(3)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .io_bus     (bus)
`ifdef NOLINEAR_CTRL_PERF_EN
        ,
        .o_op_cnt   (op_cnt),
        .o_drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {bus.busy, bus.in_ack, bus.done, bus.mode, bus.valid, bus.s_in, bus.s_mux,
                bus.s_mult, bus.s_add, bus.en_add, bus.en_mult};
    endfunction

    // Reference model: an accepted op is tracked by cycles elapsed since the accepting edge.
    bit         m_active, m_flush;
    int         m_k;
    logic [1:0] m_mode;
    int         m_ops, m_drops;

    function automatic bit two_pass(input logic [1:0] m);
        return (m == 2'b00) || (m == 2'b11);
    endfunction

    function automatic int done_k(input logic [1:0] m);
        return two_pass(m) ? 2 * L + 1 : L + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0; m_flush <= 0; m_k <= 0; m_mode <= 2'b00; m_ops <= 0; m_drops <= 0;
        end else begin
            if ((m_active || m_flush) && bus.start && m_drops < 65535) m_drops <= m_drops + 1;
            if (m_flush) begin
                m_flush <= 0;
            end else if (m_active) begin
                if (m_k == done_k(m_mode) && m_ops < 65535) m_ops <= m_ops + 1;
                if (bus.flush) begin
                    m_active <= 0; m_flush <= 1;
                end else if (m_k == done_k(m_mode)) begin
                    m_active <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (bus.start && !bus.flush) begin
                m_active <= 1; m_k <= 1; m_mode <= bus.op_mode;
            end
        end
    end

    always @(negedge clk) begin
        bit         p1, p2, tw;
        logic [2:0] sel;
        logic [15:0] req;
        tw  = two_pass(m_mode);
        p1  = m_active && (m_k <= L);
        p2  = m_active && tw && (m_k > L) && (m_k <= 2 * L);
        sel = (p1 || p2) ? {p2, m_mode} : 3'b000;
        req = {(m_active || m_flush), (m_active && m_k == 1), (m_active && m_k == done_k(m_mode)),
               m_mode, p2, sel, p2, sel, p2, (p1 && tw), (p2 || (p1 && tw))};
        check("model outputs", dut_vec(), req);
`ifdef NOLINEAR_CTRL_PERF_EN
        check("model op_cnt", op_cnt, m_ops[15:0]);
        check("model drop_cnt", drop_cnt, m_drops[15:0]);
`endif
    end

    task automatic run_op(input logic [1:0] m, input int exp_busy, input int exp_done,
                          input string tag);
        int nb = 0;
        int dat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op_mode = m;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.busy) nb++;
            if (bus.done) dat = i;
            if (i == 1) check({tag, " in_ack"}, 16'(bus.in_ack), 16'd1);
            if (m == 2'b01 && i == 1) begin
                check({tag, " en_mult p1"}, 16'(bus.en_mult), 16'd0);
                check({tag, " s_in p1"}, 16'(bus.s_in), 16'h1);
            end
            if (m == 2'b00 && i == 1) begin
                check({tag, " en_add p1"}, 16'(bus.en_add), 16'd1);
                check({tag, " s_in p1"}, 16'(bus.s_in), 16'h0);
            end
            if (m == 2'b00 && i == 5) begin
                check({tag, " valid p2"}, 16'(bus.valid), 16'd1);
                check({tag, " s_in p2"}, 16'(bus.s_in), 16'h4);
                check({tag, " s_mux p2"}, 16'(bus.s_mux), 16'd1);
            end
        end
        check({tag, " busy cycles"}, 16'(nb), 16'(exp_busy));
        check({tag, " done cycle"}, 16'(dat), 16'(exp_done));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int dat;
        bus.start = 1'b0; bus.op_mode = 2'b00; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs", dut_vec(), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b01, 5, 5, "gelu");
        run_op(2'b00, 9, 9, "softmax");
        run_op(2'b10, 5, 5, "silu");
        run_op(2'b11, 9, 9, "root");

        // Flush in PASS2 at counter 2 of a root op.
        dat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op_mode = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (i == 7);
            #1;
            if (bus.done) dat = i;
            if (i == 8) begin
                check("flush busy", 16'(bus.busy), 16'd1);
                check("flush ctrl", {6'd0, bus.valid, bus.s_in, bus.s_mux, bus.s_mult, bus.s_add,
                                     bus.en_add, bus.en_mult}, 16'h0000);
            end
            if (i == 9) check("flush to idle", 16'(bus.busy), 16'd0);
        end
        check("flush no done", 16'(dat), 16'hFFFF);

        // Flush in DONE plus a start during FLUSH.
        @(negedge clk);
        bus.start = 1'b1; bus.op_mode = 2'b10;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.start = (i == 6);
            bus.flush = (i == 5);
            #1;
            if (i == 6) check("done-flush busy", 16'(bus.busy), 16'd1);
            if (i == 7) check("done-flush idle", 16'(bus.busy), 16'd0);
        end

        // Asynchronous reset in PASS1 of silu.
        dat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op_mode = 2'b10;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", dut_vec(), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) dat = i;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) dat = i;
        end
        check("reset no done", 16'(dat), 16'hFFFF);
        run_op(2'b10, 5, 5, "silu after reset");

        // Start pulsed again during gelu, counters from a fresh reset.
        do_reset();
        dat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op_mode = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.start = (i == 2);
            #1;
            if (bus.done) dat = i;
        end
        check("dropped start done", 16'(dat), 16'd5);
        check("dropped start idle", 16'(bus.busy), 16'd0);
`ifdef NOLINEAR_CTRL_PERF_EN
        check("op_cnt", op_cnt, 16'd1);
        check("drop_cnt", drop_cnt, 16'd1);
`endif

        // start and flush together in IDLE.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op_mode = 2'b11;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("start+flush busy", 16'(bus.busy), 16'd0);
        check("start+flush mode", 16'(bus.mode), 16'h1);
        @(negedge clk);
        #1;
        check("start+flush idle", 16'(bus.busy), 16'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
